muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: XLEN, 32, operand and result width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: CLK  in  1  clock; all state updates on the rising edge.
REQ-004 Port: RESET  in  1  asynchronous active-low reset.
REQ-005 Port: START  in  1  request to begin the operation given by ALU_OP.
REQ-006 Port: ALU_OP  in  5  op code, decoded as follows.
- 11000 MUL; 11001 MULH; 11010 MULHSU; 11011 MULHU.
- 11100 DIV; 11110 DIVU; 11101 REM; 11111 REMU.
REQ-007 Port: OPERAND_A  in  XLEN  multiplicand or dividend.
REQ-008 Port: OPERAND_B  in  XLEN  multiplier or divisor.
REQ-009 Port: FLUSH  in  1  synchronous abort of any operation in progress.
REQ-010 Port: RESULT  out  XLEN  registered result; holds its value between operations.
REQ-011 Port: BUSY  out  1  high whenever state is not IDLE; drives the pipeline stall.
REQ-012 Port: DONE  out  1  one-cycle pulse; RESULT is valid while DONE is high.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and FIN; BUSY = (state != IDLE).
REQ-014 In IDLE, START=1, FLUSH=0 and ALU_OP[4:3]=2'b11 SHALL capture ALU_OP, OPERAND_A and OPERAND_B on that edge (the accepting edge) and move to CALC with iteration counter 0.
REQ-015 START SHALL be ignored outside IDLE, and when ALU_OP[4:3]!=2'b11 (state stays IDLE, no DONE).
REQ-016 Input changes after the accepting edge SHALL NOT affect the operation in progress.
REQ-017 CALC SHALL perform one radix-2 step per cycle:
- multiply: shift-add into a 2*XLEN product register;
- divide: restoring shift-subtract.
The step SHALL act on operand magnitudes.
REQ-018 CALC SHALL last exactly XLEN cycles, then go to FIN; latency is fixed for all operands, special cases included.
REQ-019 In FIN the block SHALL:
- apply sign correction and special-case selection;
- register RESULT;
- assert DONE.
On the next edge the state SHALL return to IDLE.
REQ-020 DONE SHALL be high for exactly the cycle following accepting edge + XLEN edges (XLEN+1 cycles after START is sampled).
REQ-021 Signedness:
- MUL/MULH: both operands signed;
- MULHSU: A signed, B unsigned;
- MULHU, DIVU, REMU: both unsigned;
- DIV/REM: both signed.
REQ-022 Result selection:
- MUL returns product bits [XLEN-1:0];
- MULH, MULHSU and MULHU return bits [2*XLEN-1:XLEN].
REQ-023 DIV/DIVU SHALL truncate toward zero; REM/REMU SHALL take the sign of the dividend.
REQ-024 Divide by zero:
- DIV/DIVU SHALL return all ones;
- REM/REMU SHALL return OPERAND_A.
REQ-025 Signed overflow (A = most negative value, B = -1):
- DIV SHALL return A;
- REM SHALL return 0.
REQ-026 FLUSH=1 in any state SHALL force IDLE on the next edge with no DONE and RESULT unchanged; FLUSH overrides a simultaneous START.
REQ-027 DONE and BUSY SHALL be registered-state decodes with no combinational path from inputs.

Reset
REQ-028 RESET=0 SHALL immediately, without waiting for a clock edge:
- force state IDLE;
- clear the counter, product and quotient registers;
- set RESULT=0, BUSY=0 and DONE=0.
REQ-029 RESET asserted mid-operation SHALL abort the operation; no DONE SHALL follow deassertion.
REQ-030 After RESET deasserts, START SHALL be accepted on the first rising edge.

Verification
REQ-031 MUL 7 x 0xFFFFFFFD:
- RESULT=0xFFFFFFEB;
- DONE high only in the cycle after edge 32 from acceptance;
- BUSY high for 33 cycles.
REQ-032 High-half multiplies with A=B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-033 Divide with A=0xFFFFFFF9 (-7), B=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 Special cases:
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5;
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0;
- each with standard latency.
REQ-035 Abort and ignore:
- START during CALC is ignored;
- FLUSH at CALC cycle 10 gives BUSY=0 next cycle, no DONE, RESULT holds its previous value;
- RESET=0 at CALC cycle 5 clears all outputs asynchronously.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit: one shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle on operand magnitudes,
// with sign correction and special-case selection applied at the end.
// Latency is fixed: XLEN CALC cycles followed by one FIN cycle.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      ALU_OP,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Shared datapath register: {high, low} product for multiply,
  // {partial remainder, dividend/quotient} for divide.
  logic [2*XLEN-1:0] prod_q, prod_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2:0]        op_q, op_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic              bzero_q, bzero_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at the accepting edge.
  logic              in_sa, in_sb;
  logic              in_a_neg, in_b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;

  // One iteration of each algorithm, from the registered state.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step_next;

  // Final result formation from the last step's value.
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quot_signed, rem_signed;
  logic [XLEN-1:0]   fin_val;

  // Signedness of each operand and magnitudes of the incoming operands.
  always_comb begin
    in_sa    = !(ALU_OP[2:0] == 3'b011 || ALU_OP[2:0] == 3'b110 || ALU_OP[2:0] == 3'b111);
    in_sb    = in_sa && (ALU_OP[2:0] != 3'b010);
    in_a_neg = in_sa && OPERAND_A[XLEN-1];
    in_b_neg = in_sb && OPERAND_B[XLEN-1];
    mag_a    = in_a_neg ? -OPERAND_A : OPERAND_A;
    mag_b    = in_b_neg ? -OPERAND_B : OPERAND_B;
  end

  // Radix-2 step: shift-add multiply and restoring shift-subtract divide.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    div_shift = prod_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, mcand_q};
    if (!div_diff[XLEN]) begin
      div_next = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    end
    step_next = op_q[2] ? div_next : mul_next;
  end

  // Sign correction and special-case selection applied to the final step.
  always_comb begin
    prod_signed = (a_neg_q ^ b_neg_q) ? -step_next : step_next;
    quot_signed = (a_neg_q ^ b_neg_q) ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    rem_signed  = a_neg_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
    fin_val     = '0;
    case (op_q)
      3'b000:                 fin_val = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b110: begin
        if (bzero_q)    fin_val = '1;
        else if (ovf_q) fin_val = a_q;
        else            fin_val = quot_signed;
      end
      default: begin
        if (bzero_q)    fin_val = a_q;
        else if (ovf_q) fin_val = '0;
        else            fin_val = rem_signed;
      end
    endcase
  end

  // Next-state logic: accept, iterate, finish; FLUSH overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    a_d      = a_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    bzero_d  = bzero_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (START && ALU_OP[4:3] == 2'b11) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = ALU_OP[2:0];
          a_d     = OPERAND_A;
          a_neg_d = in_a_neg;
          b_neg_d = in_b_neg;
          bzero_d = (OPERAND_B == '0);
          ovf_d   = in_sb && (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}}) && (OPERAND_B == '1);
          if (ALU_OP[2]) begin
            prod_d  = {{XLEN{1'b0}}, mag_a};
            mcand_d = mag_b;
          end else begin
            prod_d  = {{XLEN{1'b0}}, mag_b};
            mcand_d = mag_a;
          end
        end
      end
      CALC: begin
        prod_d = step_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = FIN;
          result_d = fin_val;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (FLUSH) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      a_q      <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      bzero_q  <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      a_q      <= a_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      bzero_q  <= bzero_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign BUSY   = (state_q != IDLE);
  assign DONE   = (state_q == FIN);
  assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results
// and DONE cycles; a negedge monitor pops and compares on every DONE.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;

  logic            CLK;
  logic            RESET;
  logic            START;
  logic [4:0]      ALU_OP;
  logic [XLEN-1:0] OPERAND_A;
  logic [XLEN-1:0] OPERAND_B;
  logic            FLUSH;
  logic [XLEN-1:0] RESULT;
  logic            BUSY;
  logic            DONE;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .ALU_OP    (ALU_OP),
    .OPERAND_A (OPERAND_A),
    .OPERAND_B (OPERAND_B),
    .FLUSH     (FLUSH),
    .RESULT    (RESULT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    int              cyc;
  } exp_t;

  exp_t            exp_q[$];
  int              compared   = 0;
  int              mismatched = 0;
  int              cyc        = 0;
  logic [XLEN-1:0] last_result = '0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Count rising edges so DONE timing can be checked in absolute cycles.
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model from the arithmetic definitions, using 64-bit integers.
  function automatic logic [XLEN-1:0] ref_model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    int          ai, bi;
    longint      sa, sb, ua, ub, q;
    logic [63:0] p;
    logic [XLEN-1:0] r;
    ai = a; bi = b;
    sa = ai; sb = bi;
    ua = {32'b0, a}; ub = {32'b0, b};
    r = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin q = sa / sb; p = q; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin q = sa % sb; p = q; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin q = ua / ub; p = q; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin q = ua % ub; p = q; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (RESET === 1'b1 && DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: DONE=1 with nothing outstanding, RESULT=%0h (cycle %0d)", RESULT, cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", RESULT, e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one operation at a negedge, then wait for the unit to go idle.
  task automatic run_op(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input bit inject);
    int busy_cnt;
    logic [XLEN-1:0] r;
    r = ref_model(op[2:0], a, b);
    START = 1'b1; ALU_OP = op; OPERAND_A = a; OPERAND_B = b;
    exp_q.push_back('{res: r, cyc: cyc + 1 + XLEN});
    last_result = r;
    $display("op %02h a=%08h b=%08h expect %08h", op, a, b, r);
    @(negedge CLK);
    START = 1'b0;
    ALU_OP = 5'($urandom); OPERAND_A = $urandom; OPERAND_B = $urandom;
    busy_cnt = 0;
    while (BUSY === 1'b1 && busy_cnt < 4 * XLEN) begin
      if (inject && busy_cnt == 5) begin
        START  = 1'b1;
        ALU_OP = 5'h18 | 5'($urandom_range(0, 7));
      end else begin
        START = 1'b0;
      end
      busy_cnt++;
      @(negedge CLK);
    end
    START = 1'b0;
    check("busy_cycles", busy_cnt, XLEN + 1);
    check("done_seen", exp_q.size(), 0);
    check("result_hold", RESULT, last_result);
  endtask

  // Start an operation that is expected to be aborted (nothing pushed).
  task automatic start_only(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    START = 1'b1; ALU_OP = op; OPERAND_A = a; OPERAND_B = b;
    @(negedge CLK);
    START = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    ALU_OP = '0; OPERAND_A = '0; OPERAND_B = '0;
    #2 RESET = 1'b0;
    #1;
    check("reset_result", RESULT, 0);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // Directed vectors.
    run_op(5'h18, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    run_op(5'h1B, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(5'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(5'h1A, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(5'h1C, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(5'h1D, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
    run_op(5'h1E, 32'd100, 32'd7, 1'b0);
    run_op(5'h1F, 32'd100, 32'd7, 1'b0);
    run_op(5'h1E, 32'd5, 32'd0, 1'b0);
    run_op(5'h1F, 32'd5, 32'd0, 1'b0);
    run_op(5'h1C, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(5'h1D, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Ops outside the 11xxx group are ignored.
    START = 1'b1; ALU_OP = 5'h0C; OPERAND_A = 32'd9; OPERAND_B = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    check("invalid_op_ignored", BUSY, 0);

    // FLUSH wins over a simultaneous START in IDLE.
    START = 1'b1; FLUSH = 1'b1; ALU_OP = 5'h18;
    @(negedge CLK);
    START = 1'b0; FLUSH = 1'b0;
    check("flush_over_start", BUSY, 0);

    // FLUSH in the middle of CALC.
    start_only(5'h1C, 32'd1000, 32'd3);
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    check("flush_busy", BUSY, 0);
    check("flush_done", DONE, 0);
    repeat (40) @(negedge CLK);
    check("flush_result_hold", RESULT, last_result);

    // Asynchronous reset in the middle of CALC, then start on first edge.
    start_only(5'h18, 32'd12345, 32'd678);
    repeat (4) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("async_reset_result", RESULT, 0);
    check("async_reset_busy", BUSY, 0);
    check("async_reset_done", DONE, 0);
    @(negedge CLK);
    RESET = 1'b1;
    last_result = '0;
    run_op(5'h1E, 32'd77, 32'd8, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      run_op(5'h18 | 5'($urandom_range(0, 7)), pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
